// File: rtl/mp_counter_n.sv
// mp_counter_n: N-digit BCD up/down counter with prescaler, parallel load,
// synchronous clear, terminal-count pulse and a multiplexed, registered
// seven-segment display driver with optional leading-zero blanking.
module mp_counter_n #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1,
    parameter int SCAN_DIV = 4,
    parameter int LZB      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  style,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [6:0]            disp,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] count_reg, count_next;
    logic [PW-1:0]       pre_reg, pre_next;
    logic                tc_reg, tc_next;
    logic [SW-1:0]       scan_cnt_reg, scan_cnt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [6:0]          disp_reg, disp_next;
    logic [DIGITS-1:0]   an_reg, an_next;

    logic                tick;
    logic [4*DIGITS-1:0] load_clean;
    logic [4*DIGITS-1:0] step_val;
    logic [DIGITS:0]     chain;       // carry (up) or borrow (down) into each digit
    logic [DIGITS:0]     zero_from;   // digit k and every higher digit are zero
    logic [3:0]          digit [DIGITS];
    logic [3:0]          cur_digit;
    logic                blank;

    assign tick = en && (pre_reg == PRE_LAST);

    // Per-digit slices: load sanitising, BCD step and leading-zero chain
    assign chain[0]          = 1'b1;
    assign zero_from[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] ld;
            logic [3:0] d;

            assign ld        = load_val[4*gi +: 4];
            assign d         = count_reg[4*gi +: 4];
            assign digit[gi] = d;

            // Non-BCD load digits are stored as zero
            assign load_clean[4*gi +: 4] = (ld > 4'd9) ? 4'd0 : ld;

            // A digit only moves when everything below it rolled over
            assign step_val[4*gi +: 4] = !chain[gi] ? d :
                                         style ? ((d == 4'd0) ? 4'd9 : d - 4'd1) :
                                                 ((d == 4'd9) ? 4'd0 : d + 4'd1);
            assign chain[gi+1] = chain[gi] && (style ? (d == 4'd0) : (d == 4'd9));

            assign zero_from[gi] = (d == 4'd0) && zero_from[gi+1];
        end
    endgenerate

    // Counter next state: clear beats load beats tick; carry out of the top digit is a wrap
    always_comb begin
        count_next = count_reg;
        pre_next   = pre_reg;
        tc_next    = 1'b0;
        if (clr) begin
            count_next = '0;
            pre_next   = '0;
        end else if (load) begin
            count_next = load_clean;
            pre_next   = '0;
        end else if (en) begin
            if (tick) begin
                pre_next   = '0;
                count_next = step_val;
                tc_next    = chain[DIGITS];
            end else begin
                pre_next = pre_reg + PW'(1);
            end
        end
    end

    // Scan divider and digit index: free-running, unaffected by counter controls
    always_comb begin
        scan_cnt_next = scan_cnt_reg + SW'(1);
        idx_next      = idx_reg;
        if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_next = '0;
            idx_next      = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
    end

    // Display next state: segment code of the selected digit, one anode low
    always_comb begin
        cur_digit = digit[idx_reg];
        blank     = (LZB != 0) && (idx_reg != '0) && zero_from[idx_reg];
        an_next   = ~(DIGITS'(1) << idx_reg);
        if (blank) begin
            disp_next = 7'b1111111;
        end else begin
            case (cur_digit)
                4'd0:    disp_next = 7'b1000000;
                4'd1:    disp_next = 7'b1111001;
                4'd2:    disp_next = 7'b0100100;
                4'd3:    disp_next = 7'b0110000;
                4'd4:    disp_next = 7'b0011001;
                4'd5:    disp_next = 7'b0010010;
                4'd6:    disp_next = 7'b0000010;
                4'd7:    disp_next = 7'b1111000;
                4'd8:    disp_next = 7'b0000000;
                4'd9:    disp_next = 7'b0010000;
                default: disp_next = 7'b1111111;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            pre_reg      <= '0;
            tc_reg       <= 1'b0;
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
            disp_reg     <= 7'h7F;
            an_reg       <= '1;
        end else begin
            count_reg    <= count_next;
            pre_reg      <= pre_next;
            tc_reg       <= tc_next;
            scan_cnt_reg <= scan_cnt_next;
            idx_reg      <= idx_next;
            disp_reg     <= disp_next;
            an_reg       <= an_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign disp  = disp_reg;
    assign an    = an_reg;

endmodule

// File: tb/tb_mp_counter_n.sv
// tb_mp_counter_n: table-driven check of the 4-digit counter plus directed
// sequences for display scan, prescaler, full 00..99 wrap and async reset.
module tb_mp_counter_n;

    logic clk;
    logic rst_n;

    // DUT A: 4 digits, TICK_DIV=1, SCAN_DIV=2, LZB=1
    logic        a_en, a_style, a_clr, a_load;
    logic [15:0] a_load_val, a_count;
    logic        a_tc;
    logic [6:0]  a_disp;
    logic [3:0]  a_an;

    // DUT B: 2 digits, TICK_DIV=3
    logic        b_en, b_style, b_clr, b_load;
    logic [7:0]  b_load_val, b_count;
    logic        b_tc;
    logic [6:0]  b_disp;
    logic [1:0]  b_an;

    // DUT C: 2 digits, TICK_DIV=1
    logic        c_en, c_style, c_clr, c_load;
    logic [7:0]  c_load_val, c_count;
    logic        c_tc;
    logic [6:0]  c_disp;
    logic [1:0]  c_an;

    int tests = 0;
    int fails = 0;

    mp_counter_n #(.DIGITS(4), .TICK_DIV(1), .SCAN_DIV(2), .LZB(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .style(a_style), .clr(a_clr),
        .load(a_load), .load_val(a_load_val), .count(a_count), .tc(a_tc),
        .disp(a_disp), .an(a_an)
    );

    mp_counter_n #(.DIGITS(2), .TICK_DIV(3), .SCAN_DIV(4), .LZB(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .style(b_style), .clr(b_clr),
        .load(b_load), .load_val(b_load_val), .count(b_count), .tc(b_tc),
        .disp(b_disp), .an(b_an)
    );

    mp_counter_n #(.DIGITS(2), .TICK_DIV(1), .SCAN_DIV(4), .LZB(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .style(c_style), .clr(c_clr),
        .load(c_load), .load_val(c_load_val), .count(c_count), .tc(c_tc),
        .disp(c_disp), .an(c_an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        clr;
        logic        load;
        logic        en;
        logic        style;
        logic [15:0] lv;
        logic [15:0] exp_count;
        logic        exp_tc;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    logic [6:0] dexp [4];
    logic [3:0] prev_an;
    logic [3:0] exp_an;
    logic       found;
    int         e;
    int         tc_pulses;
    logic [7:0] cexp;
    logic       b_en_seq  [11];
    logic [7:0] b_exp_seq [11];

    initial begin
        //                 clr   load  en    style lv        count     tc
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0A3F, 16'h0030, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0031, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0030, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0004, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0003, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1299, 16'h1299, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1300, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0042, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0042, 1'b0};

        dexp[0] = 7'b0100100;
        dexp[1] = 7'b0011001;
        dexp[2] = 7'b1111111;
        dexp[3] = 7'b1111111;

        // Prescaler sequence for DUT B: 4 enabled cycles, 5 idle, 2 enabled
        b_en_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        b_exp_seq = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};

        rst_n = 1'b0;
        a_en = 0; a_style = 0; a_clr = 0; a_load = 0; a_load_val = '0;
        b_en = 0; b_style = 0; b_clr = 0; b_load = 0; b_load_val = '0;
        c_en = 0; c_style = 0; c_clr = 0; c_load = 0; c_load_val = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_count", 32'(a_count), 32'h0000);
        chk("reset_tc", 32'(a_tc), 32'h0);
        chk("reset_an", 32'(a_an), 32'hF);
        chk("reset_disp", 32'(a_disp), 32'h7F);
        $display("[TB] reset: count=%h an=%b disp=%b", a_count, a_an, a_disp);
        rst_n = 1'b1;

        // First edge after release drives digit 0
        @(negedge clk);
        chk("first_an", 32'(a_an), 32'hE);
        chk("first_disp", 32'(a_disp), 32'(7'b1000000));
        $display("[TB] first edge: an=%b disp=%b", a_an, a_disp);

        // Table-driven counter vectors on DUT A
        for (int i = 0; i < NV; i++) begin
            a_clr      = vecs[i].clr;
            a_load     = vecs[i].load;
            a_en       = vecs[i].en;
            a_style    = vecs[i].style;
            a_load_val = vecs[i].lv;
            @(negedge clk);
            chk($sformatf("vec%0d_count", i), 32'(a_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_tc", i), 32'(a_tc), 32'(vecs[i].exp_tc));
            $display("[TB] vec %0d: clr=%b load=%b en=%b style=%b lv=%h -> count=%h tc=%b",
                     i, vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].style, vecs[i].lv,
                     a_count, a_tc);
        end
        a_clr = 0; a_load = 0; a_en = 0;

        // Display scan with count 0042 and leading-zero blanking
        found   = 1'b0;
        prev_an = a_an;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (prev_an !== 4'b1110 && a_an === 4'b1110) found = 1'b1;
            prev_an = a_an;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL scan_start: an never entered 1110 within 40 cycles, last an=%b", a_an);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge clk);
                exp_an = ~(4'b0001 << (i / 2));
                chk($sformatf("scan%0d_an", i), 32'(a_an), 32'(exp_an));
                chk($sformatf("scan%0d_disp", i), 32'(a_disp), 32'(dexp[i/2]));
                $display("[TB] scan %0d: an=%b disp=%b", i, a_an, a_disp);
            end
        end

        // Prescaler with EN gap on DUT B
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        chk("b_clr_count", 32'(b_count), 32'h00);
        for (int i = 0; i < 11; i++) begin
            b_en = b_en_seq[i];
            @(negedge clk);
            chk($sformatf("pre%0d_count", i), 32'(b_count), 32'(b_exp_seq[i]));
            $display("[TB] prescale %0d: en=%b -> count=%h", i, b_en, b_count);
        end
        b_en = 1'b0;

        // Full 00..99..00 up count on DUT C
        c_clr = 1'b1;
        @(negedge clk);
        c_clr = 1'b0;
        chk("c_clr_count", 32'(c_count), 32'h00);
        c_en      = 1'b1;
        e         = 0;
        tc_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            e    = (e + 1) % 100;
            cexp = {4'(e / 10), 4'(e % 10)};
            chk($sformatf("up%0d_count", i), 32'(c_count), 32'(cexp));
            chk($sformatf("up%0d_tc", i), 32'(c_tc), 32'(e == 0));
            if (c_tc === 1'b1) tc_pulses++;
            $display("[TB] up %0d: count=%h tc=%b", i, c_count, c_tc);
        end
        c_en = 1'b0;
        chk("up_tc_pulses", 32'(tc_pulses), 32'd1);

        // Asynchronous reset mid-count on DUT A
        a_load = 1'b1; a_load_val = 16'h0042;
        @(negedge clk);
        a_load = 1'b0; a_en = 1'b1; a_style = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(a_count), 32'h0000);
        chk("arst_an", 32'(a_an), 32'hF);
        chk("arst_disp", 32'(a_disp), 32'h7F);
        chk("arst_tc", 32'(a_tc), 32'h0);
        $display("[TB] async reset: count=%h an=%b disp=%b", a_count, a_an, a_disp);
        #4 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst1_count", 32'(a_count), 32'h0001);
        chk("post_rst1_an", 32'(a_an), 32'hE);
        $display("[TB] after release: count=%h an=%b", a_count, a_an);
        @(negedge clk);
        chk("post_rst2_count", 32'(a_count), 32'h0002);
        $display("[TB] after release+1: count=%h", a_count);
        a_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
